// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback stage: register file geometry,
// FSM state encoding and the {rd, value} write request.
package wb_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REGW = $clog2(NREG);

    typedef logic [REGW-1:0] reg_idx_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_HOLD = 1'b1
    } wb_state_e;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] val;
    } wb_req_t;
endpackage

// File: rtl/writeback_stage_if.sv
// Result bus from the exec unit and the dmem stage into writeback, plus the
// stall/overrun status returned upstream.
interface writeback_stage_if;
    import wb_pkg::*;

    logic            ex_valid;
    reg_idx_t        ex_rd;
    logic [XLEN-1:0] ex_value;
    logic            ld_active;
    reg_idx_t        ld_rd;
    logic [XLEN-1:0] ld_value;
    logic            wb_stall;
    logic            overrun_err;

    modport master (
        output ex_valid, ex_rd, ex_value, ld_active, ld_rd, ld_value,
        input  wb_stall, overrun_err
    );

    modport slave (
        input  ex_valid, ex_rd, ex_value, ld_active, ld_rd, ld_value,
        output wb_stall, overrun_err
    );
endinterface

// File: rtl/regfile_1w2r.sv
// Register file with one write port and two read ports that bypass the
// current-cycle write; x0 is never written and always reads zero.
module regfile_1w2r
    import wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  reg_idx_t             wa,
    input  logic [XLEN-1:0]      wd,
    input  reg_idx_t             ra1,
    input  reg_idx_t             ra2,
    output logic [XLEN-1:0]      rd1,
    output logic [XLEN-1:0]      rd2,
    output logic [NREG*XLEN-1:0] regs_flat
);
    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    function automatic logic [XLEN-1:0] read_port(input reg_idx_t ra);
        if (ra == '0)
            return '0;
        else if (we && (wa == ra))
            return wd;
        else
            return regs_q[ra];
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREG; i++) regs_flat[i*XLEN +: XLEN] = regs_q[i];
    end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits one exec or load result per cycle, parking the
// exec result for a cycle when both arrive together (the load is older).
//
// state   | meaning
// WB_IDLE | accepting inputs; load wins a collision, exec goes to hold entry
// WB_HOLD | committing the hold entry; upstream stalled, inputs ignored
module writeback_stage
    import wb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    writeback_stage_if.slave     bus,
    input  reg_idx_t             rs1_addr,
    input  reg_idx_t             rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic [NREG*XLEN-1:0] general_reg,
    output logic [31:0]          retire_cnt
);
    wb_state_e state_q, state_d;
    wb_req_t   hold_q;
    wb_req_t   wr_req;
    logic      wr_en;
    logic      capture_hold;
    logic      overrun_q;
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (bus.ld_active && bus.ex_valid) state_d = WB_HOLD;
            WB_HOLD: state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        wr_en        = 1'b0;
        wr_req       = '0;
        capture_hold = 1'b0;
        bus.wb_stall = (state_q == WB_HOLD);
        case (state_q)
            WB_IDLE: begin
                if (bus.ld_active) begin
                    wr_en        = 1'b1;
                    wr_req       = '{rd: bus.ld_rd, val: bus.ld_value};
                    capture_hold = bus.ex_valid;
                end else if (bus.ex_valid) begin
                    wr_en  = 1'b1;
                    wr_req = '{rd: bus.ex_rd, val: bus.ex_value};
                end
            end
            WB_HOLD: begin
                wr_en  = 1'b1;
                wr_req = hold_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            hold_q <= '0;
        else if (capture_hold) hold_q <= '{rd: bus.ex_rd, val: bus.ex_value};
    end

    // Sticky until reset: any valid presented while stalled was lost upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_q <= 1'b0;
        else if ((state_q == WB_HOLD) && (bus.ex_valid || bus.ld_active))
            overrun_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt_q <= '0;
        else if (wr_en) cnt_q <= cnt_q + 32'd1;
    end

    assign bus.overrun_err = overrun_q;
    assign retire_cnt      = cnt_q;

    regfile_1w2r u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wr_en),
        .wa        (wr_req.rd),
        .wd        (wr_req.val),
        .ra1       (rs1_addr),
        .ra2       (rs2_addr),
        .rd1       (rs1_data),
        .rd2       (rs2_data),
        .regs_flat (general_reg)
    );
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench: the driver models commits as an ordered write queue and
// pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_writeback_stage;
    import wb_pkg::*;

    typedef struct packed {
        logic [NREG*XLEN-1:0] gr;
        logic [31:0]          cnt;
        logic                 stall;
        logic                 ovr;
        logic [31:0]          r1;
        logic [31:0]          r2;
    } exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] v;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    reg_idx_t rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic [NREG*XLEN-1:0] general_reg;
    logic [31:0] retire_cnt;

    writeback_stage_if bus();

    writeback_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .general_reg (general_reg),
        .retire_cnt  (retire_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];
    wr_t  wq[$];
    logic [31:0] mregs [32];
    logic [31:0] mcnt;
    logic        movr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        wq.delete();
        mcnt = '0;
        movr = 1'b0;
    endtask

    // One cycle: drive inputs, predict this cycle's visible outputs, advance model.
    task automatic step(input logic ev, input logic [4:0] er, input logic [31:0] evv,
                        input logic lv, input logic [4:0] lr, input logic [31:0] lvv,
                        input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        wr_t  c;
        bit   stalled, have;
        bus.ex_valid  = ev;  bus.ex_rd = er;  bus.ex_value = evv;
        bus.ld_active = lv;  bus.ld_rd = lr;  bus.ld_value = lvv;
        rs1_addr = a1;
        rs2_addr = a2;
        stalled = (wq.size() != 0);
        if (!stalled) begin
            if (lv) wq.push_back('{rd: lr, v: lvv});
            if (ev) wq.push_back('{rd: er, v: evv});
        end
        have = (wq.size() != 0);
        c = '0;
        if (have) c = wq.pop_front();
        for (int i = 0; i < 32; i++) e.gr[i*32 +: 32] = mregs[i];
        e.cnt   = mcnt;
        e.stall = stalled;
        e.ovr   = movr;
        e.r1    = (a1 == 0) ? 32'd0 : ((have && c.rd == a1) ? c.v : mregs[a1]);
        e.r2    = (a2 == 0) ? 32'd0 : ((have && c.rd == a2) ? c.v : mregs[a2]);
        sb.push_back(e);
        if (have) begin
            mcnt = mcnt + 1;
            if (c.rd != 0) mregs[c.rd] = c.v;
        end
        if (stalled && (ev || lv)) movr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic [4:0] a1, input logic [4:0] a2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a1, a2);
    endtask

    task automatic rand_step();
        logic [4:0] er, lr;
        er = 5'($urandom_range(0, 7));
        lr = 5'($urandom_range(0, 7));
        step(1'($urandom_range(0, 1)), er, $urandom,
             1'($urandom_range(0, 1)), lr, $urandom,
             5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)),
             5'($urandom_range(0, 7)));
    endtask

    always @(negedge clk) begin
        if (rst_n && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int i = 0; i < 32; i++)
                chk($sformatf("general_reg[%0d]", i), general_reg[i*32 +: 32], e.gr[i*32 +: 32]);
            chk("retire_cnt", retire_cnt, e.cnt);
            chk("wb_stall", {31'd0, bus.wb_stall}, {31'd0, e.stall});
            chk("overrun_err", {31'd0, bus.overrun_err}, {31'd0, e.ovr});
            chk("rs1_data", rs1_data, e.r1);
            chk("rs2_data", rs2_data, e.r2);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_regs"}, {31'd0, |general_reg}, 32'd0);
        chk({tag, "_cnt"}, retire_cnt, 32'd0);
        chk({tag, "_stall"}, {31'd0, bus.wb_stall}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, bus.overrun_err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_value = 0;
        bus.ld_active = 0; bus.ld_rd = 0; bus.ld_value = 0;
        rs1_addr = 0; rs2_addr = 0;
        model_reset();
        #2;
        check_reset_outputs("reset");
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // exec-only write to x5
        step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle_step(5'd5, 5'd3);
        // load/exec collision, distinct rd
        step(1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 5'd3, 5'd4);
        idle_step(5'd3, 5'd4);
        idle_step(5'd3, 5'd4);
        // collision on the same rd: exec value lands last
        step(1, 5'd7, 32'hB, 1, 5'd7, 32'hA, 5'd7, 5'd0);
        idle_step(5'd7, 5'd7);
        idle_step(5'd7, 5'd0);
        // x0 write discarded but counted
        step(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle_step(5'd0, 5'd0);
        // same-cycle bypass to x9
        step(1, 5'd9, 32'h1234, 0, 5'd0, 32'd0, 5'd9, 5'd9);
        idle_step(5'd9, 5'd0);
        // load in the hold cycle makes overrun sticky
        step(1, 5'd2, 32'h55, 1, 5'd1, 32'h44, 5'd1, 5'd2);
        step(0, 5'd0, 32'd0, 1, 5'd6, 32'h66, 5'd6, 5'd2);
        for (int i = 0; i < 60; i++) rand_step();
        // reset while in HOLD drops the parked exec result
        step(1, 5'd12, 32'hCAFE, 1, 5'd11, 32'hBEEF, 5'd11, 5'd12);
        rst_n = 1'b0;
        bus.ex_valid = 0; bus.ld_active = 0;
        #1;
        check_reset_outputs("midhold_reset");
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle_step(5'd12, 5'd11);
        for (int i = 0; i < 300; i++) rand_step();
        idle_step(5'd1, 5'd2);

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
